pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, 2-stage pipelined carry-lookahead adder/subtractor for the miniRISC ALU path.
//  Hierarchical lookahead: 4-bit groups produce group P/G; a second level resolves group carries.
//  Elastic valid/ready handshake on input and output so the ALU can stall without dropping operands.
//  Adds ADD/SUB mode and C/V/Z flag outputs, which the single 4-bit lookahead unit does not have.
// PARAMETERS
//  WIDTH     32  operand width; multiple of 4, range 8..64 (compile-time error otherwise)
//  GROUP     4   bits per lookahead group; fixed at 4, WIDTH/GROUP groups
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active high
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts beat when in_valid & in_ready
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (ADD only)
//  sub        in   1      0 = A+B+cin, 1 = A-B (A + ~B + 1, cin ignored)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      consumer takes result when out_valid & out_ready
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  c_out      out  1      carry out of MSB (SUB: 1 = no borrow)
//  v_out      out  1      signed overflow: (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]), b' = effective B
//  z_out      out  1      sum == 0
// BEHAVIOUR
//  Reset (rst high at clk edge): out_valid=0, sum=0, c_out=0, v_out=0, z_out=0, both stage-valid bits 0.
//   in_ready is 0 while rst is high; 1 on first cycle after reset release.
//  Stage 1 (S1): on accept, register effective B (b or ~b), carry-in (cin or 1), bit p=a^b', g=a&b',
//   and per-group P/G (group P = AND of p; group G = standard 4-term lookahead). s1_valid set.
//  Stage 2 (S2): group carries c[k+1] = G[k] | P[k]&c[k], c[0]=registered carry-in, computed by
//   second-level lookahead; intra-group carries by first-level lookahead; sum = p ^ carries.
//   Registered into output regs with flags; out_valid set.
//  Latency: exactly 2 cycles accept->out_valid when unstalled; throughput 1 beat/cycle.
//  Handshake: stall = out_valid & ~out_ready. S2 loads when ~stall; S1 loads when S1 empty or S2 loads.
//   in_ready = ~rst & (~s1_valid | ~stall) (combinational, no in_valid dependence).
//   Output regs and flags hold stable while out_valid & ~out_ready.
//   in_valid/a/b/cin/sub sampled only on accept; changes while in_ready=0 ignored.
//  Simultaneous accept and drain in same cycle: both occur, no bubble, no loss.
//  Empty S1 with S2 drained: out_valid drops to 0 next cycle; sum/flags hold last value.
//  Reset mid-operation: all in-flight beats discarded, no out_valid after reset release until new accept+2.
//  Wrap-around: sum truncated to WIDTH; c_out carries the overflow bit.
// TESTING
//  1 WIDTH=32, ADD a=FFFF_FFFF b=0000_0001 cin=0 -> 2 cycles later sum=0, c=1, v=0, z=1.
//  2 ADD a=7FFF_FFFF b=1 -> sum=8000_0000, c=0, v=1, z=0; SUB a=5 b=7 -> sum=FFFF_FFFE, c=0, v=0.
//  3 Back-to-back 8 beats, out_ready=1 -> 8 results on consecutive cycles, order preserved, in_ready=1 throughout.
//  4 out_ready=0 for 5 cycles with stream on -> in_ready drops after 2 beats held; outputs stable;
//    release -> all beats delivered in order, none duplicated.
//  5 rst asserted with 2 beats in flight -> out_valid=0, in_ready=0 during rst; nothing emitted after.
//  6 WIDTH=8 and WIDTH=64: 10k random a/b/cin/sub vs behavioural +/-, flags checked every beat.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Two-stage pipelined carry-lookahead adder/subtractor for the ALU datapath.
//   Stage 1 forms the effective B operand, the bit propagate/generate terms and
//   the 4-bit group P/G terms. Stage 2 resolves the group carries with a second
//   lookahead level, expands them into bit carries inside each group and
//   registers the result together with the C/V/Z flags.
//   Both sides use a valid/ready handshake, so a stalled consumer back-pressures
//   the producer without losing or duplicating beats.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   operand beat valid
//   in_ready   beat accepted when in_valid & in_ready
//   a, b       operands (WIDTH bits)
//   cin        carry-in, used only for ADD
//   sub        0: a + b + cin, 1: a - b (a + ~b + 1)
//   out_valid  result beat valid
//   out_ready  result taken when out_valid & out_ready
//   sum        result modulo 2^WIDTH
//   c_out      carry out of the MSB (for SUB, 1 means no borrow)
//   v_out      signed overflow
//   z_out      sum == 0
module pipelined_cla_adder #(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             v_out,
   output logic             z_out
);

   localparam int NG = WIDTH / GROUP;

   if ((WIDTH % 4) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("pipelined_cla_adder: WIDTH must be a multiple of 4 in 8..64");
   end
   if (GROUP != 4) begin : g_bad_group
      $error("pipelined_cla_adder: GROUP must be 4");
   end

   // Group propagate/generate of one 4-bit group, returned as {P, G}.
   function automatic logic [1:0] grp_pg(input logic [3:0] p, input logic [3:0] g);
      logic gp;
      logic gg;
      gp = &p;
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
      return {gp, gg};
   endfunction

   // Carries into each bit of a 4-bit group, flattened lookahead from the group carry-in.
   function automatic logic [3:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                            input logic ci);
      logic [3:0] c;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return c;
   endfunction

   // Handshake control
   logic vld_p1;
   logic vld_p2;
   logic stall;
   logic ld_p2;
   logic ld_p1;
   logic accept;

   assign stall     = vld_p2 & ~out_ready;
   assign ld_p2     = ~stall;
   assign ld_p1     = ~vld_p1 | ld_p2;
   assign in_ready  = ~rst & ld_p1;
   assign accept    = in_valid & in_ready;
   assign out_valid = vld_p2;

   // Stage 1 combinational: effective operand, bit and group P/G
   logic [WIDTH-1:0] bp_in;
   logic [WIDTH-1:0] p_in;
   logic [WIDTH-1:0] g_in;
   logic [NG-1:0]    gp_in;
   logic [NG-1:0]    gg_in;

   always_comb begin
      bp_in = sub ? ~b : b;
      p_in  = a ^ bp_in;
      g_in  = a & bp_in;
      gp_in = '0;
      gg_in = '0;
      for (int k = 0; k < NG; k++) begin
         {gp_in[k], gg_in[k]} = grp_pg(p_in[k*GROUP +: GROUP], g_in[k*GROUP +: GROUP]);
      end
   end

   // ---- stage 1 register boundary ----
   logic [WIDTH-1:0] p_p1;
   logic [WIDTH-1:0] g_p1;
   logic [NG-1:0]    gp_p1;
   logic [NG-1:0]    gg_p1;
   logic             c0_p1;

   always_ff @(posedge clk) begin
      if (accept) begin
         p_p1  <= p_in;
         g_p1  <= g_in;
         gp_p1 <= gp_in;
         gg_p1 <= gg_in;
         c0_p1 <= sub | cin;
      end
   end

   // Stage 2 combinational: group carries, then bit carries inside each group
   logic [NG:0]      gc;
   logic [WIDTH:0]   c_all;
   logic [WIDTH-1:0] s_nx;
   logic             v_nx;

   always_comb begin
      gc    = '0;
      gc[0] = c0_p1;
      for (int k = 0; k < NG; k++) begin
         gc[k+1] = gg_p1[k] | (gp_p1[k] & gc[k]);
      end
      c_all = '0;
      for (int k = 0; k < NG; k++) begin
         c_all[k*GROUP +: GROUP] = grp_carry(p_p1[k*GROUP +: GROUP], g_p1[k*GROUP +: GROUP],
                                             gc[k]);
      end
      c_all[WIDTH] = gc[NG];
      s_nx = p_p1 ^ c_all[WIDTH-1:0];
      // Signed overflow is exactly a disagreement between carry-in and carry-out of the MSB.
      v_nx = c_all[WIDTH] ^ c_all[WIDTH-1];
   end

   // ---- stage 2 register boundary ----
   logic [WIDTH-1:0] sum_p2;
   logic             c_p2;
   logic             v_p2;
   logic             z_p2;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
         sum_p2 <= '0;
         c_p2   <= 1'b0;
         v_p2   <= 1'b0;
         z_p2   <= 1'b0;
      end else begin
         if (ld_p1) begin
            vld_p1 <= accept;
         end
         if (ld_p2) begin
            vld_p2 <= vld_p1;
            // Result and flags only move when a real beat advances; bubbles keep the last value.
            if (vld_p1) begin
               sum_p2 <= s_nx;
               c_p2   <= c_all[WIDTH];
               v_p2   <= v_nx;
               z_p2   <= (s_nx == '0);
            end
         end
      end
   end

   assign sum   = sum_p2;
   assign c_out = c_p2;
   assign v_out = v_p2;
   assign z_out = z_p2;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // 32-bit instance for directed tests
   logic        iv32, ir32, ci32, sb32, ov32, or32, c32, v32, z32;
   logic [31:0] a32, b32, s32;

   // 8-bit and 64-bit instances share one random stream
   logic        ivr, orr, cir, sbr;
   logic [63:0] ar, br;
   logic        ir8, ov8, c8, v8, z8;
   logic [7:0]  s8;
   logic        ir64, ov64, c64, v64, z64;
   logic [63:0] s64;

   pipelined_cla_adder #(.WIDTH(32), .GROUP(4)) u32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
      .cin(ci32), .sub(sb32), .out_valid(ov32), .out_ready(or32), .sum(s32),
      .c_out(c32), .v_out(v32), .z_out(z32));

   pipelined_cla_adder #(.WIDTH(8), .GROUP(4)) u8 (
      .clk(clk), .rst(rst), .in_valid(ivr), .in_ready(ir8), .a(ar[7:0]), .b(br[7:0]),
      .cin(cir), .sub(sbr), .out_valid(ov8), .out_ready(orr), .sum(s8),
      .c_out(c8), .v_out(v8), .z_out(z8));

   pipelined_cla_adder #(.WIDTH(64), .GROUP(4)) u64 (
      .clk(clk), .rst(rst), .in_valid(ivr), .in_ready(ir64), .a(ar), .b(br),
      .cin(cir), .sub(sbr), .out_valid(ov64), .out_ready(orr), .sum(s64),
      .c_out(c64), .v_out(v64), .z_out(z64));

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference: plain wide arithmetic, result packed as {c, v, z, sum}
   function automatic logic [66:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic cin, input logic sub);
      logic [63:0] mask, aa, bp, s;
      logic [64:0] full;
      logic        c, v, z;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      aa   = a & mask;
      bp   = (sub ? ~b : b) & mask;
      full = {1'b0, aa} + {1'b0, bp} + {64'd0, (sub ? 1'b1 : cin)};
      s    = full[63:0] & mask;
      c    = full[w];
      v    = (aa[w-1] == bp[w-1]) && (s[w-1] != aa[w-1]);
      z    = (s == 64'd0);
      return {c, v, z, s};
   endfunction

   // Scoreboard per instance: 0 = 32-bit, 1 = 8-bit, 2 = 64-bit
   logic [66:0] q [3][$];
   logic        held [3];
   logic [66:0] last [3];
   int          acc  [3];

   initial begin
      for (int i = 0; i < 3; i++) begin
         held[i] = 1'b0;
         last[i] = '0;
         acc[i]  = 0;
      end
   end

   task automatic mon(input int id, input int w, input logic iv, input logic ir,
                      input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb,
                      input logic ov, input logic ordy, input logic [63:0] s,
                      input logic c, input logic v, input logic z);
      logic [66:0] act;
      act = {c, v, z, s};
      if (rst) begin
         q[id].delete();
         held[id] = 1'b0;
         return;
      end
      if (held[id]) chk($sformatf("hold%0d", w), {60'd0, ov, act}, {60'd0, 1'b1, last[id]});
      if (ov && ordy) begin
         if (q[id].size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spurious%0d: out_valid with no beat outstanding, got %h expected none",
                     w, act);
         end else begin
            chk($sformatf("result%0d", w), {61'd0, act}, {61'd0, q[id].pop_front()});
         end
      end
      if (iv && ir) begin
         q[id].push_back(model(w, a, b, ci, sb));
         acc[id]++;
      end
      held[id] = ov && !ordy;
      last[id] = act;
   endtask

   always @(negedge clk) begin
      mon(0, 32, iv32, ir32, {32'd0, a32}, {32'd0, b32}, ci32, sb32, ov32, or32, {32'd0, s32},
          c32, v32, z32);
      mon(1, 8, ivr, ir8, ar, br, cir, sbr, ov8, orr, {56'd0, s8}, c8, v8, z8);
      mon(2, 64, ivr, ir64, ar, br, cir, sbr, ov64, orr, s64, c64, v64, z64);
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        v;
      logic        z;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int cyc;
      logic [31:0] hs;

      //          a             b             cin   sub   sum           c     v     z
      tbl[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      tbl[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
      tbl[8]  = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
      tbl[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      iv32 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0; sb32 = 1'b0; or32 = 1'b1;
      ivr = 1'b0; ar = '0; br = '0; cir = 1'b0; sbr = 1'b0; orr = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {90'd0, ov32, ir32, s32, c32, v32, z32}, 128'd0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", {127'd0, ir32}, 128'd1);

      // Single beats from the table, exact 2-cycle latency
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         a32 = tbl[i].a; b32 = tbl[i].b; ci32 = tbl[i].cin; sb32 = tbl[i].sub; iv32 = 1'b1;
         @(posedge clk); #1;
         iv32 = 1'b0;
         chk($sformatf("lat1_vec%0d", i), {127'd0, ov32}, 128'd0);
         @(posedge clk); #1;
         chk($sformatf("lat2_vec%0d", i), {127'd0, ov32}, 128'd1);
         chk($sformatf("vec%0d", i), {93'd0, s32, c32, v32, z32},
             {93'd0, tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].z});
      end
      @(posedge clk); #1;
      chk("drained_idle", {127'd0, ov32}, 128'd0);

      // Back-to-back 8 beats: full throughput, results on consecutive cycles
      for (cyc = 0; cyc < 11; cyc++) begin
         if (cyc < 8) begin
            a32 = 32'h1111_1111 * cyc; b32 = 32'h0000_0100 + cyc;
            ci32 = cyc[0]; sb32 = cyc[1]; iv32 = 1'b1;
         end else begin
            iv32 = 1'b0;
         end
         #1;
         chk($sformatf("b2b_in_ready%0d", cyc), {127'd0, ir32}, 128'd1);
         chk($sformatf("b2b_out_valid%0d", cyc), {127'd0, ov32},
             {127'd0, (cyc >= 2 && cyc < 10) ? 1'b1 : 1'b0});
         @(posedge clk); #1;
      end

      // Stall: consumer blocks for 5 cycles while the producer keeps offering beats
      k = 0;
      for (cyc = 0; cyc < 16; cyc++) begin
         or32 = (cyc < 5) ? 1'b0 : 1'b1;
         iv32 = (k < 4) ? 1'b1 : 1'b0;
         a32  = 32'hA000_0000 + k; b32 = 32'h0000_00F0 * k; ci32 = 1'b1; sb32 = k[0];
         #1;
         if (cyc < 5)
            chk($sformatf("stall_in_ready%0d", cyc), {127'd0, ir32},
                {127'd0, (cyc < 2) ? 1'b1 : 1'b0});
         if (cyc == 3) hs = s32;
         if (cyc == 4) chk("stall_sum_stable", {96'd0, s32}, {96'd0, hs});
         if (iv32 && ir32) k++;
         @(posedge clk); #1;
      end
      iv32 = 1'b0;
      chk("stall_all_accepted", 128'(k), 128'd4);
      chk("stall_all_delivered", 128'(q[0].size()), 128'd0);
      chk("stall_idle_after", {127'd0, ov32}, 128'd0);

      // Reset with two beats in flight: both discarded
      or32 = 1'b1;
      a32 = 32'h0000_0011; b32 = 32'h0000_0022; ci32 = 1'b0; sb32 = 1'b0; iv32 = 1'b1;
      @(posedge clk); #1;
      a32 = 32'h0000_0033; b32 = 32'h0000_0044;
      @(posedge clk); #1;
      iv32 = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_in_ready_low", {127'd0, ir32}, 128'd0);
      @(posedge clk); #1;
      chk("rst_out_valid_low", {127'd0, ov32}, 128'd0);
      chk("rst_in_ready_still_low", {127'd0, ir32}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk($sformatf("post_rst_quiet%0d", i), {127'd0, ov32}, 128'd0);
      end
      // A fresh beat still flows after reset
      a32 = 32'h0000_0009; b32 = 32'h0000_0003; sb32 = 1'b1; iv32 = 1'b1;
      @(posedge clk); #1;
      iv32 = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_beat", {94'd0, ov32, s32, c32}, {94'd0, 1'b1, 32'h0000_0006, 1'b1});

      // Random streams on the 8-bit and 64-bit instances with random back-pressure
      cyc = 0;
      while (acc[1] < 10000 && cyc < 40000) begin
         ivr = ($urandom_range(0, 3) != 0);
         orr = ($urandom_range(0, 3) != 0);
         ar  = {$urandom, $urandom};
         br  = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: br = ~ar;
            1: br = ar;
            2: ar = 64'd0;
            default: ;
         endcase
         cir = $urandom_range(0, 1);
         sbr = $urandom_range(0, 1);
         cyc++;
         @(posedge clk); #1;
      end
      ivr = 1'b0;
      orr = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("rand_beats8", {127'd0, (acc[1] >= 10000) ? 1'b1 : 1'b0}, 128'd1);
      chk("rand_drained8", 128'(q[1].size()), 128'd0);
      chk("rand_drained64", 128'(q[2].size()), 128'd0);
      chk("rand_equal_accepts", 128'(acc[2]), 128'(acc[1]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
